// File: rtl/bcd_counter_param_if.sv
// Control/status bundle for bcd_counter_param: the master drives count controls
// and the slave (the counter) returns its value and flags.
interface bcd_counter_param_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic                  clr;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  up_dn;
   logic [4*DIGITS-1:0]   q;
   logic [DIGITS-2:0]     ena;
   logic                  tc;
   logic                  wrap;
   logic                  load_err;

   modport master (
      output en, clr, load, load_val, up_dn,
      input  q, ena, tc, wrap, load_err
   );

   modport slave (
      input  en, clr, load, load_val, up_dn,
      output q, ena, tc, wrap, load_err
   );
endinterface

// File: rtl/bcd_counter_param.sv
// Multi-digit BCD counter with clear/load/enable; BCD_DOWN_EN adds down count via up_dn.
// q, wrap and load_err are registered (1 clk); ena and tc are combinational; no backpressure.
module bcd_counter_param #(
   parameter int DIGITS = 4
) (
   input logic                clk,
   input logic                reset,
   bcd_counter_param_if.slave bus
);
   localparam int W = 4 * DIGITS;

   logic [W-1:0]      q_r;
   logic [W-1:0]      q_nxt;
   logic [W-1:0]      ld_clean;
   logic [DIGITS:0]   low_term;
   logic [DIGITS-1:0] step;
   logic [DIGITS-1:0] bad;
   logic              dn;
   logic              tc;
   logic              wrap_r;
   logic              load_err_r;

`ifdef BCD_DOWN_EN
   assign dn = ~bus.up_dn;
`else
   logic unused_up_dn;
   assign unused_up_dn = bus.up_dn;
   assign dn           = 1'b0;
`endif

   // low_term[i]: digits 0..i-1 all sit at the terminal value for the current direction
   assign low_term[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      logic [3:0] d;
      logic [3:0] lv;
      logic [3:0] inc;
      logic [3:0] dec;

      assign d   = q_r[4*i +: 4];
      assign lv  = bus.load_val[4*i +: 4];
      assign inc = (d >= 4'd9) ? 4'd0 : d + 4'd1;
      assign dec = (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;

      assign low_term[i+1]      = low_term[i] & (dn ? (d == 4'd0) : (d == 4'd9));
      assign step[i]            = bus.en & low_term[i];
      assign q_nxt[4*i +: 4]    = step[i] ? (dn ? dec : inc) : d;
      assign bad[i]             = (lv > 4'd9);
      assign ld_clean[4*i +: 4] = bad[i] ? 4'd0 : lv;
   end

   assign tc = bus.en & low_term[DIGITS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r        <= '0;
         wrap_r     <= 1'b0;
         load_err_r <= 1'b0;
      end else if (bus.clr) begin
         q_r        <= '0;
         wrap_r     <= 1'b0;
         load_err_r <= 1'b0;
      end else if (bus.load) begin
         q_r        <= ld_clean;
         wrap_r     <= 1'b0;
         load_err_r <= |bad;
      end else begin
         q_r        <= q_nxt;
         wrap_r     <= tc;
         load_err_r <= 1'b0;
      end
   end

   assign bus.q        = q_r;
   assign bus.ena      = step[DIGITS-1:1];
   assign bus.tc       = tc;
   assign bus.wrap     = wrap_r;
   assign bus.load_err = load_err_r;

endmodule
